// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller: FSM state encoding and
// the per-program start-address table.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Entry i is the first PC of program i; narrowed to instr_width at the use site.
    localparam logic [3:0][15:0] START_TABLE = {16'd192, 16'd128, 16'd64, 16'd0};

    function automatic logic [15:0] start_entry(input logic [1:0] idx);
        return START_TABLE[idx];
    endfunction

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [width-1:0] count
);

    logic [width-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + width'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/run_ctrl.sv
// Program run sequencer: loads the PC from the start table on a go edge,
// runs until halt or watchdog expiry, then parks the PC and pulses done.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int          instr_width = 9,
    parameter int          reg_width   = 8,
    parameter logic [15:0] max_cycles  = 16'd4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   go,
    input  logic [1:0]             prog_sel,
    input  logic                   halt,
    input  logic                   branch_in,
    input  logic                   taken_in,
    input  logic [reg_width-1:0]   target_in,
    output logic                   start,
    output logic [instr_width-1:0] start_addr,
    output logic                   branch,
    output logic                   taken,
    output logic [reg_width-1:0]   target,
    output logic                   instr_valid,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [15:0]            cycle_count
);

    localparam logic [15:0] last_count = max_cycles - 16'd1;

    state_t     state_reg, state_next;
    logic       go_q_reg;
    logic [1:0] sel_q_reg;
    logic       timeout_reg, timeout_next;
    logic       go_rise;
    logic       cnt_clear, cnt_inc;

    assign go_rise = go & ~go_q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            go_q_reg    <= 1'b0;
            sel_q_reg   <= 2'd0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            go_q_reg    <= go;
            timeout_reg <= timeout_next;
            if ((state_reg == IDLE) && go_rise) begin
                sel_q_reg <= prog_sel;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        timeout_next = timeout_reg;
        start        = 1'b0;
        start_addr   = '0;
        busy         = 1'b0;
        done         = 1'b0;
        instr_valid  = 1'b0;
        branch       = 1'b0;
        taken        = 1'b0;
        target       = '0;
        cnt_clear    = 1'b0;
        cnt_inc      = 1'b0;

        case (state_reg)
            IDLE: begin
                start      = 1'b1;
                start_addr = instr_width'(start_entry(prog_sel));
                if (go_rise) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                start        = 1'b1;
                start_addr   = instr_width'(start_entry(sel_q_reg));
                busy         = 1'b1;
                cnt_clear    = 1'b1;
                timeout_next = 1'b0;
                state_next   = RUN;
            end
            RUN: begin
                instr_valid = 1'b1;
                busy        = 1'b1;
                cnt_inc     = 1'b1;
                target      = target_in;
                // A halt suppresses any branch decoded in the same cycle.
                if (halt) begin
                    state_next = FINISH;
                end else begin
                    branch = branch_in;
                    taken  = taken_in;
                    if (cycle_count == last_count) begin
                        state_next   = FINISH;
                        timeout_next = 1'b1;
                    end
                end
            end
            FINISH: begin
                start      = 1'b1;
                start_addr = instr_width'(start_entry(sel_q_reg));
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    sat_counter #(
        .width (16)
    ) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .count (cycle_count)
    );

    assign timeout = timeout_reg;

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized scoreboard bench for run_ctrl: the driver queues each run's
// expected outcome, the monitor pops it when done is seen.
module tb_run_ctrl;

    localparam int IW   = 9;
    localparam int RW   = 8;
    localparam int MAXC = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic [1:0]    prog_sel;
    logic          halt;
    logic          branch_in;
    logic          taken_in;
    logic [RW-1:0] target_in;
    logic          start;
    logic [IW-1:0] start_addr;
    logic          branch;
    logic          taken;
    logic [RW-1:0] target;
    logic          instr_valid;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [15:0]   cycle_count;

    run_ctrl #(
        .instr_width (IW),
        .reg_width   (RW),
        .max_cycles  (16'(MAXC))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .prog_sel    (prog_sel),
        .halt        (halt),
        .branch_in   (branch_in),
        .taken_in    (taken_in),
        .target_in   (target_in),
        .start       (start),
        .start_addr  (start_addr),
        .branch      (branch),
        .taken       (taken),
        .target      (target),
        .instr_valid (instr_valid),
        .busy        (busy),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int count;
        int tmo;
        int addr;
    } exp_t;

    exp_t sb[$];
    int   tbl[4] = '{0, 64, 128, 192};
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   pc_check_en = 1'b0;
    int   pc_expect = 0;
    int   pc_m = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: run results on done, plus an external PC built from DUT outputs.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                e = sb.pop_front();
                check("final_count", cycle_count, e.count);
                check("final_timeout", timeout, e.tmo);
                check("finish_addr", start_addr, e.addr);
                check("finish_start", start, 1);
                check("finish_busy", busy, 0);
            end
        end
        if (pc_check_en && instr_valid) check("pc_model", pc_m, pc_expect);
        if (start) pc_m = int'(start_addr);
        else if (branch && taken) pc_m = int'(target);
        else pc_m = pc_m + 1;
    end

    // h = RUN cycle carrying halt (0 = never); abort_at = RUN cycle asserting reset (0 = none)
    task automatic run_one(input int sel, input int h, input bit nobranch, input bit hold,
                           input bit go_preset, input int abort_at);
        int end_k;
        int tmo;
        end_k = (h > 0 && h <= MAXC) ? h : MAXC;
        tmo   = (h > 0 && h <= MAXC) ? 0 : 1;
        if (!go_preset) begin
            go = 1'b0;
            @(posedge clk); #1;
            go       = 1'b1;
            prog_sel = 2'(sel);
        end
        @(posedge clk); #1;
        prog_sel = 2'($urandom);
        if (!hold) go = 1'b0;
        #1;
        check("load_start", start, 1);
        check("load_addr", start_addr, tbl[sel]);
        check("load_busy", busy, 1);
        check("load_valid", instr_valid, 0);
        if (abort_at == 0) sb.push_back(exp_t'{end_k, tmo, tbl[sel]});
        pc_check_en = nobranch;
        for (int k = 1; k <= end_k; k++) begin
            @(posedge clk); #1;
            halt      = (k == h);
            branch_in = nobranch ? 1'b0 : 1'($urandom);
            taken_in  = 1'($urandom);
            target_in = RW'($urandom);
            if (!hold) go = 1'($urandom);
            pc_expect = tbl[sel] + k - 1;
            if (k == abort_at) reset = 1'b1;
            #1;
            check("run_valid", instr_valid, 1);
            if (instr_valid !== 1'b1) break;
            check("run_count", cycle_count, k - 1);
            check("run_branch", branch, halt ? 0 : branch_in);
            check("run_taken", taken, halt ? 0 : taken_in);
            check("run_target", target, target_in);
            if (k == 1) check("run_timeout_clear", timeout, 0);
            if (k == abort_at) break;
        end
        @(posedge clk); #1;
        halt        = 1'b0;
        branch_in   = 1'b0;
        taken_in    = 1'b0;
        pc_check_en = 1'b0;
        go          = hold;
        if (abort_at > 0) begin
            reset = 1'b0;
            #1;
            check("abort_done", done, 0);
            check("abort_count", cycle_count, 0);
            check("abort_busy", busy, 0);
            check("abort_start_addr", start_addr, tbl[prog_sel]);
        end else begin
            @(posedge clk); #1;
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("held_count", cycle_count, end_k);
            check("held_timeout", timeout, tmo);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        go        = 1'b1;
        prog_sel  = 2'd2;
        halt      = 1'b0;
        branch_in = 1'b1;
        taken_in  = 1'b1;
        target_in = 8'h55;
        repeat (2) @(posedge clk);
        #1;
        check("rst_start", start, 1);
        check("rst_start_addr", start_addr, tbl[2]);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_branch", branch, 0);
        check("rst_taken", taken, 0);
        check("rst_target", target, 0);
        check("rst_timeout", timeout, 0);
        check("rst_count", cycle_count, 0);
        branch_in = 1'b0;
        taken_in  = 1'b0;
        reset     = 1'b0;

        // go held through reset starts a run immediately
        run_one(2, 5, 1'b0, 1'b0, 1'b1, 0);
        run_one(1, $urandom_range(4, 8), 1'b1, 1'b0, 1'b0, 0);
        run_one(int'($urandom_range(0, 3)), 0, 1'b0, 1'b0, 1'b0, 0);
        run_one(2, MAXC, 1'b0, 1'b0, 1'b0, 0);
        run_one(3, 3, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("hold_busy", busy, 0);
        end
        run_one(0, 8, 1'b0, 1'b0, 1'b0, 3);
        for (int i = 0; i < 15; i++) begin
            run_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 1'b0, 1'b0, 1'b0, 0);
        end
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
